// File: rtl/grid_pkg.sv
// Shared constants, state encoding and index helpers for the grid RAM arbiter.
package grid_pkg;

  localparam int GRID_X_W = 6;
  localparam int GRID_Y_W = 5;
  localparam int CELL_W   = 3;
  localparam int NUM_REQ  = 3;

  localparam logic [1:0] REQ_LL = 2'd0;
  localparam logic [1:0] REQ_DG = 2'd1;
  localparam logic [1:0] REQ_RT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    case (oh)
      3'b010:  return REQ_DG;
      3'b100:  return REQ_RT;
      default: return REQ_LL;
    endcase
  endfunction

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/grid_arbiter_rr_picker.sv
// Round-robin winner selection over three requesters, starting the search at ptr.
module rr_picker
  import grid_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot_s;
  logic [NUM_REQ-1:0] pick_s;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    case (ptr)
      2'd1:    rot_s = {req[0], req[2], req[1]};
      2'd2:    rot_s = {req[1], req[0], req[2]};
      default: rot_s = req;
    endcase

    if (rot_s[0]) begin
      pick_s = 3'b001;
    end else if (rot_s[1]) begin
      pick_s = 3'b010;
    end else if (rot_s[2]) begin
      pick_s = 3'b100;
    end else begin
      pick_s = 3'b000;
    end

    case (ptr)
      2'd1:    win = {pick_s[1], pick_s[0], pick_s[2]};
      2'd2:    win = {pick_s[0], pick_s[2], pick_s[1]};
      default: win = pick_s;
    endcase

    valid = |req;
  end

endmodule

// File: rtl/grid_arbiter.sv
// Single-port grid RAM arbiter: req/gnt ownership, round-robin handover with a
// one-cycle drain gap, optional burst limit and per-requester read-valid strobes.
module grid_arbiter
  import grid_pkg::*;
#(
  parameter int MAX_BURST = 64,
  parameter int NUM_REQ   = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           en,
  input  logic [NUM_REQ-1:0]           we,
  input  logic [NUM_REQ*GRID_X_W-1:0]  req_x,
  input  logic [NUM_REQ*GRID_Y_W-1:0]  req_y,
  input  logic [NUM_REQ*CELL_W-1:0]    req_wd,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [CELL_W-1:0]            rdata,
  output logic [GRID_X_W-1:0]          grid_x,
  output logic [GRID_Y_W-1:0]          grid_y,
  output logic                         grid_write,
  output logic [CELL_W-1:0]            grid_in,
  input  logic [CELL_W-1:0]            grid_out
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

  arb_state_e          state_r;
  arb_state_e          state_nxt_s;
  logic [NUM_REQ-1:0]  gnt_r;
  logic [NUM_REQ-1:0]  rvalid_r;
  logic [1:0]          rr_ptr_r;
  logic [CNT_W-1:0]    burst_cnt_r;
  logic [1:0]          owner_s;
  logic [NUM_REQ-1:0]  pick_win_s;
  logic                pick_valid_s;
  logic                burst_hit_s;
  logic                release_s;
  logic                access_s;
  logic                rd_access_s;

  assign owner_s = onehot_to_idx(gnt_r);
  assign gnt     = gnt_r;
  assign rvalid  = rvalid_r;
  assign rdata   = grid_out;

  rr_picker u_rr_picker (
    .req   (req),
    .ptr   (rr_ptr_r),
    .win   (pick_win_s),
    .valid (pick_valid_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; IDLE and DRAIN arbitrate identically.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DRAIN: begin
        if (pick_valid_s) begin
          state_nxt_s = OWN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN: begin
        if (release_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = OWN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Owner access path; an access in the release cycle is dropped entirely.
  always_comb begin
    burst_hit_s = 1'b0;
    release_s   = 1'b0;
    access_s    = 1'b0;
    rd_access_s = 1'b0;
    grid_write  = 1'b0;
    grid_x      = {GRID_X_W{1'b0}};
    grid_y      = {GRID_Y_W{1'b0}};
    grid_in     = {CELL_W{1'b0}};
    if (state_r == OWN) begin
      grid_x      = req_x[owner_s*GRID_X_W +: GRID_X_W];
      grid_y      = req_y[owner_s*GRID_Y_W +: GRID_Y_W];
      grid_in     = req_wd[owner_s*CELL_W +: CELL_W];
      burst_hit_s = (MAX_BURST != 0) && (burst_cnt_r == CNT_W'(MAX_BURST))
                    && (|(req & ~gnt_r));
      release_s   = ~req[owner_s] | burst_hit_s;
      access_s    = reset & en[owner_s] & ~release_s;
      grid_write  = access_s & we[owner_s] & gnt_r[owner_s];
      rd_access_s = access_s & ~we[owner_s];
    end else begin
      release_s = 1'b0;
    end
  end

  // Grant, read-valid, round-robin pointer and burst counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gnt_r       <= {NUM_REQ{1'b0}};
      rvalid_r    <= {NUM_REQ{1'b0}};
      rr_ptr_r    <= 2'd0;
      burst_cnt_r <= {CNT_W{1'b0}};
    end else begin
      rvalid_r <= rd_access_s ? gnt_r : {NUM_REQ{1'b0}};
      case (state_r)
        IDLE, DRAIN: begin
          gnt_r       <= pick_valid_s ? pick_win_s : {NUM_REQ{1'b0}};
          burst_cnt_r <= {CNT_W{1'b0}};
        end
        OWN: begin
          if (release_s) begin
            gnt_r    <= {NUM_REQ{1'b0}};
            rr_ptr_r <= next_idx(owner_s);
          end
          if (access_s && (burst_cnt_r != CNT_W'(MAX_BURST))) begin
            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          gnt_r <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed bench for grid_arbiter with a behavioural synchronous grid RAM.
module tb_grid_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, en, we;
  logic [17:0] req_x;
  logic [14:0] req_y;
  logic [8:0]  req_wd;
  logic [2:0]  gnt, rvalid, rdata;
  logic [5:0]  grid_x;
  logic [4:0]  grid_y;
  logic        grid_write;
  logic [2:0]  grid_in;
  logic [2:0]  grid_out;

  bit [2:0] mem [0:31][0:63];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  grid_arbiter #(.MAX_BURST(4), .NUM_REQ(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .en         (en),
    .we         (we),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_wd     (req_wd),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .grid_x     (grid_x),
    .grid_y     (grid_y),
    .grid_write (grid_write),
    .grid_in    (grid_in),
    .grid_out   (grid_out)
  );

  // Synchronous RAM, one-cycle read latency.
  always @(posedge clock) begin
    if (grid_write) mem[grid_y][grid_x] <= grid_in;
    grid_out <= mem[grid_y][grid_x];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fields(input int idx, input logic [5:0] x, input logic [4:0] y,
                            input logic [2:0] wd);
    req_x[idx*6 +: 6]  = x;
    req_y[idx*5 +: 5]  = y;
    req_wd[idx*3 +: 3] = wd;
  endtask

  initial begin
    int cur;
    int nxt;
    logic [2:0] oh_cur;
    logic [2:0] oh_nxt;

    reset = 1'b0; req = 3'b111; en = 3'b000; we = 3'b000;
    req_x = 18'd0; req_y = 15'd0; req_wd = 9'd0;

    // Reset held with all requests high
    repeat (2) begin
      tick();
      chk("rst_gnt", gnt, 3'b000);
      chk("rst_rvalid", rvalid, 3'b000);
      chk("rst_grid_write", grid_write, 1'b0);
    end
    reset = 1'b1;
    tick();
    chk("first_gnt", gnt, 3'b001);

    // Hand over to requester 1
    req = 3'b010;
    tick();
    chk("drain_gap", gnt, 3'b000);
    tick();
    chk("gnt_dg", gnt, 3'b010);

    // Write (5,3)=6 then read it back
    set_fields(1, 6'd5, 5'd3, 3'd6);
    en = 3'b010; we = 3'b010;
    #1;
    chk("wr_strobe", grid_write, 1'b1);
    chk("wr_x", grid_x, 6'd5);
    chk("wr_y", grid_y, 5'd3);
    chk("wr_data", grid_in, 3'd6);
    tick();
    chk("wr_no_rvalid", rvalid, 3'b000);
    we = 3'b000;
    tick();
    chk("rd_rvalid", rvalid, 3'b010);
    chk("rd_data", rdata, 3'd6);
    en = 3'b000;

    // Round-robin: each owner reads twice, drops req for one cycle
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      cur = (1 + i) % 3;
      nxt = (cur + 1) % 3;
      oh_cur = 3'b001 << cur;
      oh_nxt = 3'b001 << nxt;
      set_fields(cur, 6'd5, 5'd3, 3'd0);
      en = oh_cur;
      tick();
      tick();
      chk("rr_rvalid", rvalid, oh_cur);
      chk("rr_rdata", rdata, 3'd6);
      en = 3'b000;
      req = 3'b111 & ~oh_cur;
      tick();
      chk("rr_drain", gnt, 3'b000);
      req = 3'b111;
      tick();
      chk("rr_next", gnt, oh_nxt);
    end

    // Give the grid to requester 2, then stream writes with requester 0 waiting
    req = 3'b100;
    tick();
    chk("to_rt_gap", gnt, 3'b000);
    tick();
    chk("gnt_rt", gnt, 3'b100);
    req = 3'b101;
    set_fields(2, 6'd10, 5'd7, 3'd0);
    en = 3'b100; we = 3'b100;
    for (int k = 1; k <= 4; k++) begin
      req_wd[8:6] = 3'(k);
      #1;
      chk("burst_wr", grid_write, 1'b1);
      tick();
    end
    chk("burst_still_owner", gnt, 3'b100);
    req_wd[8:6] = 3'd5;
    #1;
    chk("burst_5th_no_wr", grid_write, 1'b0);
    tick();
    chk("burst_drop", gnt, 3'b000);
    chk("burst_5th_no_rvalid", rvalid, 3'b000);
    en = 3'b000; we = 3'b000;
    tick();
    chk("burst_handover", gnt, 3'b001);

    // Non-owner requester 2 pokes the grid while requester 0 owns it
    req = 3'b001;
    set_fields(2, 6'd5, 5'd3, 3'd7);
    en = 3'b100; we = 3'b100;
    #1;
    chk("iso_no_wr", grid_write, 1'b0);
    tick();
    chk("iso_no_rvalid_w", rvalid, 3'b000);
    we = 3'b000;
    tick();
    chk("iso_no_rvalid_r", rvalid, 3'b000);
    en = 3'b000;

    // Owner 0 confirms (5,3) unchanged and (10,7) holds the 4th burst write
    set_fields(0, 6'd5, 5'd3, 3'd0);
    en = 3'b001;
    tick();
    chk("iso_rvalid", rvalid, 3'b001);
    chk("iso_cell_kept", rdata, 3'd6);
    set_fields(0, 6'd10, 5'd7, 3'd0);
    tick();
    chk("burst_cell_rvalid", rvalid, 3'b001);
    chk("burst_cell_data", rdata, 3'd4);

    // Reset lands on the edge of an owner read
    reset = 1'b0;
    tick();
    chk("midrst_rvalid", rvalid, 3'b000);
    chk("midrst_gnt", gnt, 3'b000);
    reset = 1'b1; req = 3'b000; en = 3'b000;
    tick();
    chk("post_rst_gnt", gnt, 3'b000);
    chk("post_rst_rvalid", rvalid, 3'b000);
    chk("post_rst_grid_write", grid_write, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
